// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   DEFAULT_WIDTH : default operand/result width
//   OP_*          : opcode encodings (9..15 are unsupported)
//   state_e       : controller state encoding
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 12;

  localparam logic [3:0] OP_ABS = 4'd0;
  localparam logic [3:0] OP_SHL = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_ADD = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath: ABS, AND, OR, XOR, NOT, ADD, SUB and
// the unsupported-opcode response.
//   i_op      : opcode
//   i_a, i_b  : two's complement operands
//   o_z       : result
//   o_carry   : carry (ADD) / borrow (SUB), otherwise 0
//   o_ov      : signed overflow
//   o_illegal : opcode is not supported
// SHL and MUL are multi-cycle and produced by seq_alu; here they yield zeros.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_z,
  output logic             o_carry,
  output logic             o_ov,
  output logic             o_illegal
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_neg;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_neg  = '0 - i_a;

  always_comb begin
    o_z       = '0;
    o_carry   = 1'b0;
    o_ov      = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_ABS: begin
        o_z  = i_a[WIDTH-1] ? w_neg : i_a;
        // Only the most negative value negates to itself (still negative).
        o_ov = i_a[WIDTH-1] & w_neg[WIDTH-1];
      end
      OP_AND: o_z = i_a & i_b;
      OP_OR:  o_z = i_a | i_b;
      OP_XOR: o_z = i_a ^ i_b;
      OP_NOT: o_z = ~i_a;
      OP_ADD: begin
        o_z     = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ov    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_z     = w_diff[WIDTH-1:0];
        o_carry = w_diff[WIDTH];
        o_ov    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SHL, OP_MUL: begin
        // Multi-cycle ops, handled by the sequencer.
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand beat handshake (A, B, OP)
//   out_valid/out_ready  : result handshake
//   Z, CarryOut          : registered result and carry/borrow/shift-out bit
//   Sign, OV, Zero       : flags (Sign and Zero derived from registered Z)
//   Illegal              : last op used an unsupported opcode
// Single-cycle ops go IDLE->DONE; SHL shifts one bit per BUSY cycle and MUL
// runs a WIDTH-cycle shift-add iteration. Results persist until the next op
// completes.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             CarryOut,
  output logic             Sign,
  output logic             OV,
  output logic             Zero,
  output logic             Illegal
);

  // Wide enough for both WIDTH (MUL) and 2**SHW-1 (largest shift amount).
  localparam int unsigned CntW = SHW + 1;

  state_e           r_state;
  state_e           w_state_next;

  logic [3:0]       r_op;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_z;
  logic             r_carry;
  logic             r_ov;
  logic             r_illegal;

  logic             w_accept;
  logic             w_last;
  logic             w_multi;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_psum;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic [WIDTH-1:0] w_sh_next;
  logic [WIDTH-1:0] w_comb_z;
  logic             w_comb_carry;
  logic             w_comb_ov;
  logic             w_comb_illegal;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu_comb (
    .i_op     (OP),
    .i_a      (A),
    .i_b      (B),
    .o_z      (w_comb_z),
    .o_carry  (w_comb_carry),
    .o_ov     (w_comb_ov),
    .o_illegal(w_comb_illegal)
  );

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = B[SHW-1:0];
  assign w_multi  = (OP == OP_MUL) || ((OP == OP_SHL) && (w_shamt != '0));
  assign w_last   = (r_state == StBusy) && (r_cnt == CntW'(1));

  // Shift-add step: {r_hi, r_lo} holds partial product, r_lo starts as B.
  assign w_psum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_hi_next = w_psum[WIDTH:1];
  assign w_lo_next = {w_psum[0], r_lo[WIDTH-1:1]};

  // Shift step for SHL, data kept in r_lo.
  assign w_sh_next = {r_lo[WIDTH-2:0], 1'b0};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_multi ? StBusy : StDone;
        end
      end
      StBusy: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      StIdle:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: begin
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_z       <= '0;
      r_carry   <= 1'b0;
      r_ov      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op <= OP;
      if (OP == OP_MUL) begin
        r_mcand <= A;
        r_hi    <= '0;
        r_lo    <= B;
        r_cnt   <= CntW'(WIDTH);
      end else if (OP == OP_SHL) begin
        r_lo  <= A;
        r_cnt <= {1'b0, w_shamt};
        if (w_shamt == '0) begin
          r_z       <= A;
          r_carry   <= 1'b0;
          r_ov      <= 1'b0;
          r_illegal <= 1'b0;
        end
      end else begin
        r_z       <= w_comb_z;
        r_carry   <= w_comb_carry;
        r_ov      <= w_comb_ov;
        r_illegal <= w_comb_illegal;
      end
    end else if (r_state == StBusy) begin
      r_cnt <= r_cnt - CntW'(1);
      if (r_op == OP_MUL) begin
        r_hi <= w_hi_next;
        r_lo <= w_lo_next;
        if (w_last) begin
          r_z       <= w_lo_next;
          r_ov      <= |w_hi_next;
          r_carry   <= 1'b0;
          r_illegal <= 1'b0;
        end
      end else begin
        r_lo <= w_sh_next;
        if (w_last) begin
          r_z       <= w_sh_next;
          r_carry   <= r_lo[WIDTH-1];
          r_ov      <= 1'b0;
          r_illegal <= 1'b0;
        end
      end
    end
  end

  assign Z        = r_z;
  assign CarryOut = r_carry;
  assign OV       = r_ov;
  assign Illegal  = r_illegal;
  assign Sign     = r_z[WIDTH-1];
  assign Zero     = (r_z == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=12.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a_s;
  logic [11:0] b_s;
  logic [3:0]  op_s;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] z;
  logic        carry;
  logic        sign;
  logic        ov;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(
    .WIDTH(12)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_s),
    .B        (b_s),
    .OP       (op_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (z),
    .CarryOut (carry),
    .Sign     (sign),
    .OV       (ov),
    .Zero     (zero),
    .Illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [11:0] ez, input logic ec,
                           input logic eov, input logic eill);
    check_eq({tag, ":valid"}, 32'(out_valid), 32'(1));
    check_eq({tag, ":Z"}, 32'(z), 32'(ez));
    check_eq({tag, ":C"}, 32'(carry), 32'(ec));
    check_eq({tag, ":OV"}, 32'(ov), 32'(eov));
    check_eq({tag, ":Sign"}, 32'(sign), 32'(ez[11]));
    check_eq({tag, ":Zero"}, 32'(zero), 32'(ez == 12'h000));
    check_eq({tag, ":Ill"}, 32'(illegal), 32'(eill));
  endtask

  // Issue one beat, then count BUSY cycles until out_valid (bounded).
  task automatic do_op(input string tag, input logic [3:0] op, input logic [11:0] a,
                       input logic [11:0] b, input int exp_busy);
    int busy;
    @(negedge clk);
    check_eq({tag, ":in_ready"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    op_s     = op;
    a_s      = a;
    b_s      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy     = 0;
    while (!out_valid && busy < 100) begin
      @(posedge clk);
      #1;
      busy++;
    end
    check_eq({tag, ":busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ":idle"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_s       = '0;
    b_s       = '0;
    op_s      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst:in_ready", 32'(in_ready), 32'(1));
    check_eq("rst:out_valid", 32'(out_valid), 32'(0));
    check_eq("rst:Z", 32'(z), 32'(0));
    check_eq("rst:Zero", 32'(zero), 32'(1));
    check_eq("rst:flags", {28'(0), carry, sign, ov, illegal}, 32'(0));

    do_op("add", OP_ADD, 12'h7FF, 12'h001, 0);
    check_res("add", 12'h800, 1'b0, 1'b1, 1'b0);
    take("add");
    do_op("sub", OP_SUB, 12'h000, 12'h001, 0);
    check_res("sub", 12'hFFF, 1'b1, 1'b0, 1'b0);
    take("sub");
    do_op("abs_min", OP_ABS, 12'h800, 12'h000, 0);
    check_res("abs_min", 12'h800, 1'b0, 1'b1, 1'b0);
    take("abs_min");
    do_op("abs_neg", OP_ABS, 12'hFFE, 12'h000, 0);
    check_res("abs_neg", 12'h002, 1'b0, 1'b0, 1'b0);
    take("abs_neg");
    do_op("and", OP_AND, 12'hF0F, 12'h3C3, 0);
    check_res("and", 12'h303, 1'b0, 1'b0, 1'b0);
    take("and");
    do_op("or", OP_OR, 12'hF0F, 12'h3C3, 0);
    check_res("or", 12'hFCF, 1'b0, 1'b0, 1'b0);
    take("or");
    do_op("xor", OP_XOR, 12'hF0F, 12'h3C3, 0);
    check_res("xor", 12'hCCC, 1'b0, 1'b0, 1'b0);
    take("xor");
    do_op("not", OP_NOT, 12'hF0F, 12'h3C3, 0);
    check_res("not", 12'h0F0, 1'b0, 1'b0, 1'b0);
    take("not");
    do_op("shl3", OP_SHL, 12'h801, 12'h003, 3);
    check_res("shl3", 12'h008, 1'b0, 1'b0, 1'b0);
    take("shl3");
    do_op("shl0", OP_SHL, 12'h801, 12'h000, 0);
    check_res("shl0", 12'h801, 1'b0, 1'b0, 1'b0);
    take("shl0");
    do_op("shl1", OP_SHL, 12'h801, 12'h001, 1);
    check_res("shl1", 12'h002, 1'b1, 1'b0, 1'b0);
    take("shl1");
    do_op("shl15", OP_SHL, 12'hFFF, 12'h00F, 15);
    check_res("shl15", 12'h000, 1'b0, 1'b0, 1'b0);
    take("shl15");
    do_op("mul40", OP_MUL, 12'h040, 12'h040, 12);
    check_res("mul40", 12'h000, 1'b0, 1'b1, 1'b0);
    take("mul40");
    do_op("mul35", OP_MUL, 12'h003, 12'h005, 12);
    check_res("mul35", 12'h00F, 1'b0, 1'b0, 1'b0);
    take("mul35");

    // Backpressure: hold out_ready low while offering a competing beat.
    do_op("bp", OP_ADD, 12'h123, 12'h456, 0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp:valid", 32'(out_valid), 32'(1));
      check_eq("bp:in_ready", 32'(in_ready), 32'(0));
      check_eq("bp:Z", 32'(z), 32'h579);
      in_valid = 1'b1;
      op_s     = OP_SUB;
      a_s      = 12'hFFF;
      b_s      = 12'h001;
      @(posedge clk);
      #1;
    end
    check_res("bp_hold", 12'h579, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("bp:released", 32'(out_valid), 32'(0));
    check_eq("bp:retain", 32'(z), 32'h579);
    @(posedge clk);
    #1;
    check_eq("bp:no_accept", 32'(out_valid), 32'(0));
    check_eq("bp:still_idle", 32'(in_ready), 32'(1));

    // Reset in the middle of a MUL.
    @(negedge clk);
    in_valid = 1'b1;
    op_s     = OP_MUL;
    a_s      = 12'h003;
    b_s      = 12'h005;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mrst:busy", 32'(in_ready), 32'(0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("mrst:in_ready", 32'(in_ready), 32'(1));
    check_eq("mrst:out_valid", 32'(out_valid), 32'(0));
    check_eq("mrst:Z", 32'(z), 32'(0));
    check_eq("mrst:Zero", 32'(zero), 32'(1));
    check_eq("mrst:flags", {28'(0), carry, sign, ov, illegal}, 32'(0));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_eq("mrst:no_result", 32'(seen), 32'(0));

    do_op("mul_after", OP_MUL, 12'h003, 12'h005, 12);
    check_res("mul_after", 12'h00F, 1'b0, 1'b0, 1'b0);
    take("mul_after");
    do_op("illegal", 4'hA, 12'h123, 12'h456, 0);
    check_res("illegal", 12'h000, 1'b0, 1'b0, 1'b1);
    take("illegal");
    do_op("add_legal", OP_ADD, 12'h001, 12'h002, 0);
    check_res("add_legal", 12'h003, 1'b0, 1'b0, 1'b0);
    take("add_legal");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
